// File: rtl/disp_pkg.sv
// Shared seven-segment definitions for the multiplexed display controller:
// segment indices, the active-high hex glyph table and the pin polarity helper.
package disp_pkg;

  typedef enum int {
    SEG_A = 0,
    SEG_B = 1,
    SEG_C = 2,
    SEG_D = 3,
    SEG_E = 4,
    SEG_F = 5,
    SEG_G = 6
  } seg_idx_e;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Glyphs are stored active-high with bit 0 = segment a, bit 6 = segment g.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic pol_bit(input logic on, input logic active_low);
    return on ^ active_low;
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-high seven-segment decoder.
module hex_to_seg7
  import disp_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[hex];

endmodule

// File: rtl/mux_display_ctrl.sv
// Time-multiplexed N-digit seven-segment scanner with PWM brightness, per-frame
// snapshots and a frame strobe. Define DISPCTL_LZB_EN for leading-zero blanking.
module mux_display_ctrl
  import disp_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DIV_WIDTH  = 16,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [DIV_WIDTH-1:0]    div_load,
  input  logic [3:0]              brightness,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic POL = (ACTIVE_LOW != 0);
  localparam logic OFF_LVL = pol_bit(1'b0, POL);
  localparam logic [NUM_DIGITS-1:0] AN_ONE = NUM_DIGITS'(1);

  logic [DIV_WIDTH-1:0]    cnt_r;
  logic [IDX_W-1:0]        idx_r;
  logic [3:0]              pwm_r;
  logic [4*NUM_DIGITS-1:0] snap_digits_r;
  logic [NUM_DIGITS-1:0]   snap_dp_r;
  logic                    load_pending_r;

  logic                    slot_tick_s;
  logic                    wrap_s;
  logic [4*NUM_DIGITS-1:0] src_digits_s;
  logic [NUM_DIGITS-1:0]   src_dp_s;
  logic [3:0]              digit_arr_s [NUM_DIGITS];
  logic [3:0]              cur_hex_s;
  logic [6:0]              dec_s;
  logic [NUM_DIGITS-1:0]   blank_s;
  logic [6:0]              seg_hi_s;
  logic                    an_on_s;
  logic [NUM_DIGITS-1:0]   an_hi_s;
  logic [6:0]              seg_pin_s;
  logic                    dp_pin_s;
  logic [NUM_DIGITS-1:0]   an_pin_s;
  logic                    frame_start_s;

  assign slot_tick_s = (cnt_r >= div_load);
  assign wrap_s      = slot_tick_s && (idx_r == LAST_IDX);

  // Until the first post-reset capture lands, show the live inputs so the very
  // first slot already displays the fresh sample instead of the cleared snapshot.
  assign src_digits_s = load_pending_r ? digits : snap_digits_r;
  assign src_dp_s     = load_pending_r ? dp_in  : snap_dp_r;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_split
    assign digit_arr_s[g] = src_digits_s[4*g +: 4];
  end

  assign cur_hex_s = digit_arr_s[idx_r];

  hex_to_seg7 u_dec (
    .hex (cur_hex_s),
    .seg (dec_s)
  );

`ifdef DISPCTL_LZB_EN
  logic zero_run_s;

  // Blank every digit above the most significant nonzero one unless its dp is lit.
  always_comb begin
    zero_run_s = 1'b1;
    blank_s    = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run_s = zero_run_s && (digit_arr_s[i] == 4'h0);
      blank_s[i] = zero_run_s && !src_dp_s[i];
    end
    blank_s[0] = 1'b0;
  end
`else
  assign blank_s = '0;
`endif

  assign seg_hi_s      = blank_s[idx_r] ? SEG_BLANK : dec_s;
  assign an_on_s       = (brightness == 4'd15) || (pwm_r < brightness);
  assign an_hi_s       = an_on_s ? (AN_ONE << idx_r) : '0;
  assign frame_start_s = (idx_r == '0) && (cnt_r == '0) && !load_pending_r;

  // Map the active-high next-state values onto the configured pin polarity.
  always_comb begin
    seg_pin_s = '0;
    an_pin_s  = '0;
    for (int i = 0; i < 7; i++) begin
      seg_pin_s[i] = pol_bit(seg_hi_s[i], POL);
    end
    dp_pin_s = pol_bit(src_dp_s[idx_r], POL);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      an_pin_s[i] = pol_bit(an_hi_s[i], POL);
    end
  end

  // Prescaler, scan index, PWM, snapshot capture and registered pin drivers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r          <= '0;
      idx_r          <= '0;
      pwm_r          <= 4'd0;
      snap_digits_r  <= '0;
      snap_dp_r      <= '0;
      load_pending_r <= 1'b1;
      seg            <= {7{OFF_LVL}};
      dp             <= OFF_LVL;
      an             <= {NUM_DIGITS{OFF_LVL}};
      frame_tick     <= 1'b0;
    end else begin
      cnt_r <= slot_tick_s ? '0 : cnt_r + DIV_WIDTH'(1);
      pwm_r <= slot_tick_s ? 4'd0 : pwm_r + 4'd1;
      if (slot_tick_s) begin
        idx_r <= wrap_s ? '0 : idx_r + IDX_W'(1);
      end else begin
        idx_r <= idx_r;
      end
      if (load_pending_r || wrap_s) begin
        snap_digits_r <= digits;
        snap_dp_r     <= dp_in;
      end else begin
        snap_digits_r <= snap_digits_r;
        snap_dp_r     <= snap_dp_r;
      end
      load_pending_r <= 1'b0;
      seg            <= seg_pin_s;
      dp             <= dp_pin_s;
      an             <= an_pin_s;
      frame_tick     <= frame_start_s;
    end
  end

endmodule

// File: tb/tb_mux_display_ctrl.sv
// Scoreboard bench for mux_display_ctrl (4 digits, active-low pins).
module tb_mux_display_ctrl;

  localparam int ND = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] digits;
  logic [3:0]  dp_in;
  logic [15:0] div_load;
  logic [3:0]  brightness;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_tick;

  typedef struct {
    int         cyc;
    string      tag;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       ft;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   base  = 0;

  // Per-digit glyph tables packed {d3,d2,d1,d0}, active-low pin values.
  localparam logic [27:0] SEG_2578 = {7'h24, 7'h12, 7'h78, 7'h00};
  localparam logic [27:0] SEG_1234 = {7'h79, 7'h24, 7'h30, 7'h19};
  localparam logic [27:0] SEG_8888 = {7'h00, 7'h00, 7'h00, 7'h00};
  localparam logic [27:0] SEG_1111 = {7'h79, 7'h79, 7'h79, 7'h79};
`ifdef DISPCTL_LZB_EN
  localparam logic [27:0] SEG_0030 = {7'h40, 7'h7F, 7'h30, 7'h40};
`else
  localparam logic [27:0] SEG_0030 = {7'h40, 7'h40, 7'h30, 7'h40};
`endif

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  mux_display_ctrl #(
    .NUM_DIGITS (ND),
    .DIV_WIDTH  (16),
    .ACTIVE_LOW (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .digits     (digits),
    .dp_in      (dp_in),
    .div_load   (div_load),
    .brightness (brightness),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_tick (frame_tick)
  );

  task automatic expect_at(input int c, input string tag, input logic [6:0] s,
                           input logic d, input logic [3:0] a, input logic f);
    exp_t e;
    e.cyc = c;
    e.tag = tag;
    e.seg = s;
    e.dp  = d;
    e.an  = a;
    e.ft  = f;
    sb.push_back(e);
  endtask

  // Expected outputs for n cycles of scanning starting at cycle c0 at the
  // start of a slot of first_digit; slots are len cycles long.
  task automatic push_scan(input int c0, input string tag, input int first_digit,
                           input int n, input int len, input logic [3:0] br,
                           input logic [27:0] segtab, input logic [3:0] dpv,
                           input bit first_wrap);
    int         slot;
    int         pos;
    int         d;
    logic       on;
    logic [3:0] a;
    logic       f;
    for (int j = 0; j < n; j++) begin
      slot = j / len;
      pos  = j % len;
      d    = (first_digit + slot) % ND;
      on   = (br == 4'd15) || ((pos % 16) < int'(br));
      a    = on ? ~(4'b0001 << d) : 4'b1111;
      f    = (pos == 0) && (d == 0) && ((slot > 0) || first_wrap);
      expect_at(c0 + j, tag, segtab[d*7 +: 7], ~dpv[d], a, f);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    expect_at(cyc + 1, "reset", 7'h7F, 1'b1, 4'hF, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    base  = cyc;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: pops and checks every expectation due at the current cycle.
  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        mon_e = sb.pop_front();
        n_cmp++;
        if (mon_e.cyc < cyc) begin
          n_bad++;
          $display("FAIL %s cyc %0d: expectation not sampled (now cyc %0d)",
                   mon_e.tag, mon_e.cyc, cyc);
        end else if ({seg, dp, an, frame_tick} !== {mon_e.seg, mon_e.dp, mon_e.an, mon_e.ft}) begin
          n_bad++;
          $display("FAIL %s cyc %0d: got seg=%h dp=%b an=%b ft=%b, want seg=%h dp=%b an=%b ft=%b",
                   mon_e.tag, mon_e.cyc, seg, dp, an, frame_tick,
                   mon_e.seg, mon_e.dp, mon_e.an, mon_e.ft);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish (pending %0d)", sb.size());
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    digits     = 16'h2578;
    dp_in      = 4'h0;
    div_load   = 16'd9;
    brightness = 4'd15;

    // Basic scan across two frame wraps, then a reset in the middle of a slot.
    do_reset();
    push_scan(base + 1, "scan", 0, 95, 10, 4'd15, SEG_2578, 4'h0, 1'b0);
    wait_until(base + 95);
    digits = 16'h1234;
    do_reset();
    push_scan(base + 1, "post_reset", 0, 41, 10, 4'd15, SEG_1234, 4'h0, 1'b0);
    wait_until(base + 41);

    // PWM brightness 4/16 and fully dark.
    digits     = 16'h2578;
    div_load   = 16'd15;
    brightness = 4'd4;
    do_reset();
    push_scan(base + 1, "bright4", 0, 64, 16, 4'd4, SEG_2578, 4'h0, 1'b0);
    wait_until(base + 64);
    brightness = 4'd0;
    do_reset();
    push_scan(base + 1, "dark", 0, 64, 16, 4'd0, SEG_2578, 4'h0, 1'b0);
    wait_until(base + 64);

    // Snapshot: input change mid-frame shows only after the wrap.
    digits     = 16'h8888;
    div_load   = 16'd9;
    brightness = 4'd15;
    do_reset();
    push_scan(base + 1, "snap_old", 0, 40, 10, 4'd15, SEG_8888, 4'h0, 1'b0);
    push_scan(base + 41, "snap_new", 0, 10, 10, 4'd15, SEG_1111, 4'h0, 1'b1);
    wait_until(base + 15);
    digits = 16'h1111;
    wait_until(base + 50);

    // div_load = 0: one digit per clock.
    digits   = 16'h2578;
    div_load = 16'd0;
    do_reset();
    push_scan(base + 1, "div0", 0, 12, 1, 4'd15, SEG_2578, 4'h0, 1'b0);
    wait_until(base + 12);

    // div_load lowered below cnt mid-slot: slot ends on the next clock.
    div_load = 16'd9;
    do_reset();
    push_scan(base + 1, "lower_a", 0, 7, 10, 4'd15, SEG_2578, 4'h0, 1'b0);
    push_scan(base + 8, "lower_b", 1, 10, 3, 4'd15, SEG_2578, 4'h0, 1'b0);
    wait_until(base + 6);
    div_load = 16'd2;
    wait_until(base + 17);

    // Leading zeros with a decimal point on the top digit.
    digits   = 16'h0030;
    dp_in    = 4'b1000;
    div_load = 16'd3;
    do_reset();
    push_scan(base + 1, "lzb", 0, 17, 4, 4'd15, SEG_0030, 4'b1000, 1'b0);
    wait_until(base + 17);

    for (int k = 0; k < 5 && sb.size() > 0; k++) @(negedge clk);
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
